match_judge: RTL and testbench

Game-level pairing controller for the lianliankan board. It watches the `sel` outputs of all `card` instances and captures the first two newly selected, still-visible cards. It compares their face values and answers with per-card `ms` (match success) or `mf` (match fail) pulses, which the cards consume to hide or un-select themselves. It also tracks remaining pairs and flags board completion.

---
 rtl/lianliankan_pkg.sv | 16 +
 rtl/match_judge_checker.sv | 15 +
 rtl/pair_pick.sv | 39 +++
 rtl/match_judge.sv | 176 +++++++++++++++++
 tb/tb_match_judge.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/lianliankan_pkg.sv
// Shared types and board-wide defaults for the lianliankan game.
package lianliankan_pkg;

  // Default board geometry, shared with card and the board top.
  localparam int LLK_N_CARDS = 16;
  localparam int LLK_VAL_W   = 4;

  // Pair-judging controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_CMP  = 2'd2,
    ST_WAIT = 2'd3
  } judge_state_t;

endpackage

// File: rtl/match_judge_checker.sv
// Safety checks for match_judge: the remaining-pair count must never be
// decremented once it has reached zero.
module match_judge_checker #(
  parameter int PW = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          dec,
  input logic [PW-1:0] pairs_left
);

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && (pairs_left == '0)));

endmodule

// File: rtl/pair_pick.sv
// Finds the lowest and second-lowest set bits of a vector, optionally
// skipping one excluded index. Purely combinational.
module pair_pick #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] excl,
  input  logic          excl_en,
  output logic [IW-1:0] first,
  output logic          first_valid,
  output logic [IW-1:0] second,
  output logic          second_valid
);

  // Scan upward, recording the first two qualifying bits.
  always_comb begin
    first        = '0;
    second       = '0;
    first_valid  = 1'b0;
    second_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i] && !(excl_en && (excl == IW'(i)))) begin
        if (!first_valid) begin
          first       = IW'(i);
          first_valid = 1'b1;
        end else if (!second_valid) begin
          second       = IW'(i);
          second_valid = 1'b1;
        end else begin
          second_valid = 1'b1;
        end
      end else begin
        first_valid = first_valid;
      end
    end
  end

endmodule

// File: rtl/match_judge.sv
// Pairing controller: captures the first two newly selected visible cards,
// compares their faces and answers each with a match or fail pulse.
module match_judge
  import lianliankan_pkg::*;
#(
  parameter int N_CARDS   = LLK_N_CARDS,
  parameter int VAL_W     = LLK_VAL_W,
  parameter int FAIL_HOLD = 25_000_000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_CARDS-1:0]                sel,
  input  logic [N_CARDS-1:0]                hidden,
  input  logic [N_CARDS*VAL_W-1:0]          values,
  output logic [N_CARDS-1:0]                ms,
  output logic [N_CARDS-1:0]                mf,
  output logic                              busy,
  output logic [$clog2(N_CARDS/2+1)-1:0]    pairs_left,
  output logic                              done
);

  localparam int IW = $clog2(N_CARDS);
  localparam int PW = $clog2(N_CARDS/2+1);
  localparam int CW = (FAIL_HOLD > 1) ? $clog2(FAIL_HOLD) : 1;

  judge_state_t       state_r, state_n;
  logic [N_CARDS-1:0] sel_q;
  logic [IW-1:0]      a_r, a_n, b_r, b_n;
  logic [CW-1:0]      cnt_r, cnt_n;
  logic [PW-1:0]      pairs_n;
  logic [N_CARDS-1:0] ms_n, mf_n;
  logic [N_CARDS-1:0] rise_s, taken_s, pair_ms_s, pair_mf_s;
  logic [VAL_W-1:0]   val_a_s, val_b_s;
  logic [IW-1:0]      first_s, second_s;
  logic               first_vld_s, second_vld_s, dec_s;

  // One-hot mask for a card index.
  function automatic logic [N_CARDS-1:0] bit_of(input logic [IW-1:0] idx);
    logic [N_CARDS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Fresh selections of visible cards; ignored once the board is cleared.
  always_comb begin
    if (done) begin
      rise_s = '0;
    end else begin
      rise_s = sel & ~sel_q & ~hidden;
    end
  end

  assign val_a_s = values[a_r*VAL_W +: VAL_W];
  assign val_b_s = values[b_r*VAL_W +: VAL_W];

  pair_pick #(
    .N  (N_CARDS),
    .IW (IW)
  ) u_pick (
    .vec          (rise_s),
    .excl         (a_r),
    .excl_en      (state_r == ST_ONE),
    .first        (first_s),
    .first_valid  (first_vld_s),
    .second       (second_s),
    .second_valid (second_vld_s)
  );

  // Next-state logic, pair verdicts and stray-edge rejection.
  always_comb begin
    state_n   = state_r;
    a_n       = a_r;
    b_n       = b_r;
    cnt_n     = cnt_r;
    pairs_n   = pairs_left;
    taken_s   = '0;
    pair_ms_s = '0;
    pair_mf_s = '0;
    dec_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (first_vld_s && second_vld_s) begin
          a_n     = first_s;
          b_n     = second_s;
          taken_s = bit_of(first_s) | bit_of(second_s);
          state_n = ST_CMP;
        end else if (first_vld_s) begin
          a_n     = first_s;
          taken_s = bit_of(first_s);
          state_n = ST_ONE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ONE: begin
        if (!sel[a_r]) begin
          // First card was toggled off: forget it silently.
          state_n = ST_IDLE;
        end else if (first_vld_s) begin
          b_n     = first_s;
          taken_s = bit_of(first_s);
          state_n = ST_CMP;
        end else begin
          state_n = ST_ONE;
        end
      end
      ST_CMP: begin
        if (val_a_s == val_b_s) begin
          pair_ms_s = bit_of(a_r) | bit_of(b_r);
          dec_s     = 1'b1;
          if (pairs_left != '0) begin
            pairs_n = pairs_left - PW'(1);
          end else begin
            pairs_n = pairs_left;
          end
          state_n = ST_IDLE;
        end else begin
          cnt_n   = CW'(FAIL_HOLD - 1);
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_r == '0) begin
          pair_mf_s = bit_of(a_r) | bit_of(b_r);
          state_n   = ST_IDLE;
        end else begin
          cnt_n = cnt_r - CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // Uncaptured edges are rejected; a pair success always wins.
    ms_n = pair_ms_s;
    mf_n = (pair_mf_s | (rise_s & ~taken_s)) & ~pair_ms_s;
  end

  // State, capture registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sel_q      <= '0;
      a_r        <= '0;
      b_r        <= '0;
      cnt_r      <= '0;
      ms         <= '0;
      mf         <= '0;
      busy       <= 1'b0;
      pairs_left <= PW'(N_CARDS / 2);
      done       <= 1'b0;
    end else begin
      state_r    <= state_n;
      sel_q      <= sel;
      a_r        <= a_n;
      b_r        <= b_n;
      cnt_r      <= cnt_n;
      ms         <= ms_n;
      mf         <= mf_n;
      busy       <= (state_n == ST_CMP) || (state_n == ST_WAIT);
      pairs_left <= pairs_n;
      done       <= (pairs_n == '0);
    end
  end

  match_judge_checker #(
    .PW (PW)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .dec        (dec_s),
    .pairs_left (pairs_left)
  );

endmodule

// File: tb/tb_match_judge.sv
// Self-checking bench for match_judge: directed scenarios plus random card
// activity, all compared against a transaction-level reference model.
module tb_match_judge;

  localparam int N  = 4;
  localparam int VW = 2;
  localparam int FH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sel_v = '0;
  logic [N-1:0] hidden_v = '0;
  logic [N*VW-1:0] values_v = 8'b1010_0101;
  logic [N-1:0] ms, mf;
  logic         busy, done;
  logic [1:0]   pairs_left;

  match_judge #(.N_CARDS(N), .VAL_W(VW), .FAIL_HOLD(FH)) dut (
    .clk(clk), .rst(rst), .sel(sel_v), .hidden(hidden_v), .values(values_v),
    .ms(ms), .mf(mf), .busy(busy), .pairs_left(pairs_left), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int           picked[$];
  int           cyc = 0, judge_cyc = -1, fail_cyc = -1;
  int           m_pairs = N / 2;
  logic [N-1:0] m_prev_sel = '0;
  logic [N-1:0] e_ms = '0, e_mf = '0;
  bit           e_busy = 1'b0;

  // accumulators over a scenario window
  logic [N-1:0] acc_ms, acc_mf;
  int           busy_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int face(input int i);
    logic [N*VW-1:0] v;
    v = values_v;
    return int'(v[i*VW +: VW]);
  endfunction

  task automatic model_reset();
    picked.delete();
    m_pairs    = N / 2;
    m_prev_sel = '0;
    e_ms       = '0;
    e_mf       = '0;
    e_busy     = 1'b0;
    judge_cyc  = -1;
    fail_cyc   = -1;
  endtask

  // One clock of the game rules: who is picked, when the verdict lands.
  task automatic model_step();
    logic [N-1:0] r;
    e_ms = '0;
    e_mf = '0;
    r = sel_v & ~m_prev_sel & ~hidden_v;
    if (m_pairs == 0) r = '0;
    m_prev_sel = sel_v;
    if (picked.size() == 2) begin
      e_mf = r;
      if (cyc == judge_cyc) begin
        if (face(picked[0]) == face(picked[1])) begin
          e_ms[picked[0]] = 1'b1;
          e_ms[picked[1]] = 1'b1;
          m_pairs--;
          picked.delete();
        end else begin
          fail_cyc = cyc + FH;
        end
      end else if (cyc == fail_cyc) begin
        e_mf[picked[0]] = 1'b1;
        e_mf[picked[1]] = 1'b1;
        picked.delete();
      end
    end else if (picked.size() == 1 && !sel_v[picked[0]]) begin
      picked.delete();
      e_mf = r;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if (picked.size() < 2) begin
            picked.push_back(i);
            if (picked.size() == 2) judge_cyc = cyc + 1;
          end else begin
            e_mf[i] = 1'b1;
          end
        end
      end
    end
    e_mf   = e_mf & ~e_ms;
    e_busy = (picked.size() == 2);
    cyc++;
  endtask

  // Advance one clock, compare every output, then let the cards react.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_val("ms", 32'(ms), 32'(e_ms));
    check_val("mf", 32'(mf), 32'(e_mf));
    check_val("busy", 32'(busy), 32'(e_busy));
    check_val("pairs_left", 32'(pairs_left), 32'(m_pairs));
    check_val("done", 32'(done), 32'(m_pairs == 0));
    acc_ms   = acc_ms | ms;
    acc_mf   = acc_mf | mf;
    busy_cnt += int'(busy);
    hidden_v = hidden_v | e_ms;
    sel_v    = sel_v & ~(e_ms | e_mf);
  endtask

  task automatic clear_acc();
    acc_ms   = '0;
    acc_mf   = '0;
    busy_cnt = 0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    sel_v    = '0;
    hidden_v = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_acc();
    // reset held with two cards selected
    sel_v = 4'b0011;
    #1;
    tick(); tick(); tick();
    check_val("rst_ms_acc", 32'(acc_ms | acc_mf), 32'd0);
    check_val("rst_pairs", 32'(pairs_left), 32'd2);
    check_val("rst_busy", 32'(busy_cnt), 32'd0);
    sel_v = '0;
    rst   = 1'b0;

    // match 0/1 with a gap
    clear_acc();
    sel_v[0] = 1'b1; tick(); tick(); tick();
    sel_v[1] = 1'b1; tick(); tick(); tick();
    check_val("s2_ms", 32'(acc_ms), 32'(4'b0011));
    check_val("s2_mf", 32'(acc_mf), 32'd0);
    check_val("s2_busy", 32'(busy_cnt), 32'd1);
    check_val("s2_pairs", 32'(pairs_left), 32'd1);

    // mismatch 0/2
    do_reset(); clear_acc();
    sel_v[0] = 1'b1; tick();
    sel_v[2] = 1'b1; tick();
    repeat (8) tick();
    check_val("s3_mf", 32'(acc_mf), 32'(4'b0101));
    check_val("s3_ms", 32'(acc_ms), 32'd0);
    check_val("s3_busy", 32'(busy_cnt), 32'd5);
    check_val("s3_pairs", 32'(pairs_left), 32'd2);

    // toggle-off then re-pair
    do_reset(); clear_acc();
    sel_v[2] = 1'b1; tick();
    sel_v[2] = 1'b0; tick();
    sel_v[3] = 1'b1; tick(); tick();
    check_val("s4_quiet", 32'(acc_ms | acc_mf), 32'd0);
    check_val("s4_busy0", 32'(busy_cnt), 32'd0);
    sel_v[2] = 1'b1; tick(); tick(); tick();
    check_val("s4_ms", 32'(acc_ms), 32'(4'b1100));
    check_val("s4_busy", 32'(busy_cnt), 32'd1);

    // three simultaneous edges
    do_reset(); clear_acc();
    sel_v = 4'b1101; tick();
    check_val("s5_extra", 32'(mf), 32'(4'b1000));
    repeat (8) tick();
    check_val("s5_mf", 32'(acc_mf), 32'(4'b1101));
    check_val("s5_ms", 32'(acc_ms), 32'd0);
    check_val("s5_busy", 32'(busy_cnt), 32'd5);

    // clear the board, hidden cards ignored
    do_reset(); clear_acc();
    sel_v = 4'b0011; tick(); tick(); tick();
    check_val("s6_pairs1", 32'(pairs_left), 32'd1);
    clear_acc();
    sel_v[0] = 1'b1; tick(); tick(); tick();
    check_val("s6_hidden", 32'(acc_ms | acc_mf), 32'd0);
    sel_v = 4'b1100; tick(); tick(); tick();
    check_val("s6_pairs0", 32'(pairs_left), 32'd0);
    check_val("s6_done", 32'(done), 32'd1);
    clear_acc();
    sel_v = 4'b0000; tick();
    sel_v = 4'b0001; tick(); tick(); tick();
    check_val("s6_after", 32'(acc_ms | acc_mf), 32'd0);

    // random card activity with random faces
    for (int round = 0; round < 40; round++) begin
      values_v = 8'($urandom);
      do_reset();
      for (int c = 0; c < 60; c++) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, hidden_v[i] ? 19 : 5) == 0) sel_v[i] = ~sel_v[i];
        end
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
